// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and decode; tags each dequeued entry with a 64-bit order.
// Optional same-cycle empty-queue bypass enabled by defining INST_QUEUE_BYPASS_EN.
module inst_queue #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [31:0]      enq_inst,
  input  logic [31:0]      enq_pc,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [31:0]      deq_inst,
  output logic [31:0]      deq_pc,
  output logic [63:0]      deq_order,
  output logic [PTR_W:0]   count
);

  logic [31:0]    inst_mem_q [DEPTH];
  logic [31:0]    pc_mem_q   [DEPTH];
  logic [PTR_W:0] head_q, head_d;
  logic [PTR_W:0] tail_q, tail_d;
  logic [63:0]    order_q, order_d;
  logic           empty, full;
  logic           enq_fire, deq_fire, wr_en, bypass;

  assign empty = (head_q == tail_q);
  assign full  = (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]) && (head_q[PTR_W] != tail_q[PTR_W]);

  assign enq_ready = !full && !flush;
  assign count     = tail_q - head_q;
  assign deq_order = order_q;
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_valid && deq_ready;

`ifdef INST_QUEUE_BYPASS_EN
  assign bypass    = empty && enq_valid && !flush;
  assign deq_valid = !flush && (!empty || enq_valid);
  assign deq_inst  = bypass ? enq_inst : (deq_valid ? inst_mem_q[head_q[PTR_W-1:0]] : '0);
  assign deq_pc    = bypass ? enq_pc   : (deq_valid ? pc_mem_q[head_q[PTR_W-1:0]]   : '0);
`else
  assign bypass    = 1'b0;
  assign deq_valid = !empty && !flush;
  assign deq_inst  = deq_valid ? inst_mem_q[head_q[PTR_W-1:0]] : '0;
  assign deq_pc    = deq_valid ? pc_mem_q[head_q[PTR_W-1:0]]   : '0;
`endif

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    order_d = order_q;
    wr_en   = 1'b0;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else if (bypass && deq_ready) begin
      // Bypassed entry is consumed straight from the inputs; nothing is stored.
      order_d = order_q + 64'd1;
    end else begin
      if (enq_fire) begin
        wr_en  = 1'b1;
        tail_d = tail_q + 1'b1;
      end
      if (deq_fire) begin
        head_d  = head_q + 1'b1;
        order_d = order_q + 64'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      order_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      order_q <= order_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      inst_mem_q[tail_q[PTR_W-1:0]] <= enq_inst;
      pc_mem_q[tail_q[PTR_W-1:0]]   <= enq_pc;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue (DEPTH=16); expectations follow INST_QUEUE_BYPASS_EN.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst, flush, enq_valid, enq_ready, deq_valid, deq_ready;
  logic [31:0] enq_inst, enq_pc, deq_inst, deq_pc;
  logic [63:0] deq_order;
  logic [4:0]  count;

  int n_cmp = 0;
  int n_err = 0;
  int sb[$];
  int exp_cnt;
  int next_id;
  logic [63:0] exp_order;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_inst  (enq_inst),
    .enq_pc    (enq_pc),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_inst  (deq_inst),
    .deq_pc    (deq_pc),
    .deq_order (deq_order),
    .count     (count)
  );

  function automatic logic [31:0] inst_of(input int i);
    return 32'h0000_0013 + (32'(i) << 8);
  endfunction

  function automatic logic [31:0] pc_of(input int i);
    return 32'h6000_0000 + 32'(i) * 32'd4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_enq(input int i);
    enq_valid = 1'b1;
    enq_inst  = inst_of(i);
    enq_pc    = pc_of(i);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    enq_inst = '0; enq_pc = '0;
    #12;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("rst_enq_ready", 64'(enq_ready), 64'd1);
    chk("rst_order", deq_order, 64'd0);
    chk("rst_inst", 64'(deq_inst), 64'd0);
    chk("rst_pc", 64'(deq_pc), 64'd0);
    rst = 1'b0;
    tick();

    // First enqueue and its latency
    drive_enq(0);
    #1;
`ifdef INST_QUEUE_BYPASS_EN
    chk("first_same_cycle_valid", 64'(deq_valid), 64'd1);
`else
    chk("first_same_cycle_valid", 64'(deq_valid), 64'd0);
`endif
    tick();
    enq_valid = 1'b0;
    #1;
    chk("first_valid", 64'(deq_valid), 64'd1);
    chk("first_inst", 64'(deq_inst), 64'h0000_0013);
    chk("first_pc", 64'(deq_pc), 64'h6000_0000);
    chk("first_order", deq_order, 64'd0);
    chk("first_count", 64'(count), 64'd1);

    // Fill to 16, then a 17th enqueue must be refused
    for (int i = 1; i < 16; i++) begin
      drive_enq(i);
      tick();
    end
    enq_valid = 1'b0;
    chk("full_count", 64'(count), 64'd16);
    chk("full_enq_ready", 64'(enq_ready), 64'd0);
    drive_enq(99);
    tick();
    enq_valid = 1'b0;
    chk("full_17th_count", 64'(count), 64'd16);

    // Drain all 16 in order
    deq_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", 64'(deq_valid), 64'd1);
      chk("drain_pc", 64'(deq_pc), 64'(pc_of(i)));
      chk("drain_inst", 64'(deq_inst), 64'(inst_of(i)));
      chk("drain_order", deq_order, 64'(i));
      tick();
    end
    deq_ready = 1'b0;
    #1;
    chk("drained_count", 64'(count), 64'd0);
    chk("drained_valid", 64'(deq_valid), 64'd0);
    chk("drained_order", deq_order, 64'd16);

    // Fill, then sustained enqueue+dequeue with scoreboard
    next_id = 16;
    for (int i = 0; i < 16; i++) begin
      drive_enq(next_id);
      sb.push_back(next_id);
      next_id++;
      tick();
    end
    enq_valid = 1'b0;
    chk("stream_fill_count", 64'(count), 64'd16);
    exp_cnt = 16;
    exp_order = 64'd16;
    deq_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      drive_enq(next_id);
      #1;
      chk("stream_valid", 64'(deq_valid), 64'd1);
      chk("stream_pc", 64'(deq_pc), 64'(pc_of(sb[0])));
      chk("stream_order", deq_order, exp_order);
      chk("stream_count", 64'(count), 64'(exp_cnt));
      chk("stream_enq_ready", 64'(exp_cnt < 16), 64'(enq_ready));
      tick();
      void'(sb.pop_front());
      exp_order++;
      if (exp_cnt < 16) begin
        sb.push_back(next_id);
        next_id++;
      end else begin
        exp_cnt--;
      end
    end
    enq_valid = 1'b0;
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      chk("tail_drain_pc", 64'(deq_pc), 64'(pc_of(sb[0])));
      chk("tail_drain_order", deq_order, exp_order);
      tick();
      void'(sb.pop_front());
      exp_order++;
    end
    deq_ready = 1'b0;
    #1;
    chk("stream_end_count", 64'(count), 64'd0);
    chk("stream_end_valid", 64'(deq_valid), 64'd0);
    chk("stream_end_order", deq_order, 64'd71);

    // Flush with 5 entries queued and order=3
    rst = 1'b1; #1; rst = 1'b0;
    tick();
    for (int i = 40; i < 48; i++) begin
      drive_enq(i);
      tick();
    end
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    deq_ready = 1'b0;
    #1;
    chk("preflush_count", 64'(count), 64'd5);
    chk("preflush_order", deq_order, 64'd3);
    flush = 1'b1;
    drive_enq(200);
    #1;
    chk("flush_cycle_valid", 64'(deq_valid), 64'd0);
    chk("flush_cycle_enq_ready", 64'(enq_ready), 64'd0);
    tick();
    flush = 1'b0;
    enq_valid = 1'b0;
    #1;
    chk("postflush_count", 64'(count), 64'd0);
    chk("postflush_valid", 64'(deq_valid), 64'd0);
    chk("postflush_order", deq_order, 64'd3);
    drive_enq(50);
    tick();
    enq_valid = 1'b0;
    #1;
    chk("postflush_enq_valid", 64'(deq_valid), 64'd1);
    chk("postflush_enq_pc", 64'(deq_pc), 64'(pc_of(50)));
    chk("postflush_enq_order", deq_order, 64'd3);
    chk("postflush_enq_count", 64'(count), 64'd1);

    // Asynchronous reset mid-stream at count=7, order=9
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    for (int i = 60; i < 72; i++) begin
      drive_enq(i);
      tick();
    end
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    deq_ready = 1'b0;
    #1;
    chk("prerst_count", 64'(count), 64'd7);
    chk("prerst_order", deq_order, 64'd9);
    chk("prerst_pc", 64'(deq_pc), 64'(pc_of(65)));
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_valid", 64'(deq_valid), 64'd0);
    chk("midrst_enq_ready", 64'(enq_ready), 64'd1);
    chk("midrst_order", deq_order, 64'd0);
    rst = 1'b0;
    tick();

    // Empty queue with enqueue and dequeue both offered
    drive_enq(1);
    deq_ready = 1'b1;
    #1;
`ifdef INST_QUEUE_BYPASS_EN
    chk("bypass_valid", 64'(deq_valid), 64'd1);
    chk("bypass_pc", 64'(deq_pc), 64'h6000_0004);
    tick();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    #1;
    chk("bypass_count", 64'(count), 64'd0);
    chk("bypass_order", deq_order, 64'd1);
`else
    chk("nobypass_valid", 64'(deq_valid), 64'd0);
    tick();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    #1;
    chk("nobypass_count", 64'(count), 64'd1);
    chk("nobypass_next_valid", 64'(deq_valid), 64'd1);
    chk("nobypass_next_pc", 64'(deq_pc), 64'h6000_0004);
    chk("nobypass_order", deq_order, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
